// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, writeback select codes and writeback entry type
package alu_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_REG_AW = 5;

    localparam logic [5:0] ALU_OP_ADD = 6'd1;
    localparam logic [5:0] ALU_OP_SUB = 6'd2;
    localparam logic [5:0] ALU_OP_AND = 6'd3;
    localparam logic [5:0] ALU_OP_OR  = 6'd4;
    localparam logic [5:0] ALU_OP_XOR = 6'd5;
    localparam logic [5:0] ALU_OP_NOR = 6'd6;
    localparam logic [5:0] ALU_OP_SLT = 6'd7;
    localparam logic [5:0] ALU_OP_SLL = 6'd8;
    localparam logic [5:0] ALU_OP_SRL = 6'd9;
    localparam logic [5:0] ALU_OP_SEQ = 6'd10;
    localparam logic [5:0] ALU_OP_MUL = 6'd11;

    localparam logic [1:0] WB_SEL_RES  = 2'd0;
    localparam logic [1:0] WB_SEL_HI   = 2'd1;
    localparam logic [1:0] WB_SEL_LO   = 2'd2;
    localparam logic [1:0] WB_SEL_NONE = 2'd3;

    typedef struct packed {
        logic [WB_REG_AW-1:0] rd;
        logic [WB_DATA_W-1:0] data;
        logic                 we;
        logic                 is_zero;
    } wb_entry_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: 2-entry valid/ready buffer (output register + skid), registered in_ready
module pipe_skid_buf
    import alu_pkg::*;
#(
    parameter type T = wb_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic skid_valid;
    T     skid_data;
    logic accept;

    assign in_ready = !skid_valid;
    assign accept   = in_valid & in_ready;

    // EMPTY/ONE/TWO occupancy: fill the output register first, spill to skid only under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else if (!out_valid) begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end
        end else if (!skid_valid) begin
            if (accept && out_ready)
                out_data <= in_data;
            else if (out_ready)
                out_valid <= 1'b0;
            else if (accept) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end else if (out_ready) begin
            out_data   <= skid_data;
            skid_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: ALU-to-writeback stage with HI/LO registers; optional counters under ALU_WB_PERF_EN
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [DATA_W-1:0] in_result1,
    input  logic [DATA_W-1:0] in_result2,
    input  logic              in_is_zero,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [1:0]        in_wb_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_we,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_is_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
`ifdef ALU_WB_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_mul_cnt
`endif
);

    if (DATA_W != WB_DATA_W || REG_AW != WB_REG_AW) begin : g_width_check
        $error("alu_wb_stage widths must match alu_pkg wb_entry_t");
    end

    wb_entry_t in_e;
    wb_entry_t out_e;
    logic      accept;
    logic      is_mul;

    assign accept = in_valid & in_ready;
    assign is_mul = in_op == ALU_OP_MUL;

    // build the entry at accept time from pre-update HI/LO
    always_comb begin
        in_e.rd      = in_rd;
        in_e.data    = in_wb_sel == WB_SEL_RES ? in_result1 :
                       in_wb_sel == WB_SEL_HI  ? hi :
                       in_wb_sel == WB_SEL_LO  ? lo : '0;
        in_e.we      = in_wb_sel != WB_SEL_NONE && in_rd != '0;
        in_e.is_zero = in_is_zero;
    end

    pipe_skid_buf #(.T(wb_entry_t)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_e),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_e)
    );

    assign out_we      = out_valid & out_e.we;
    assign out_rd      = out_e.rd;
    assign out_data    = out_e.data;
    assign out_is_zero = out_e.is_zero;

    // an accepted multiply updates HI/LO at the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (accept && is_mul) begin
            hi <= in_result1;
            lo <= in_result2;
        end
    end

`ifdef ALU_WB_PERF_EN
    // saturating stall and multiply counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_mul_cnt   <= '0;
        end else begin
            if (in_valid && !in_ready && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (accept && is_mul && perf_mul_cnt != '1)
                perf_mul_cnt <= perf_mul_cnt + 32'd1;
        end
    end
`endif

endmodule
